mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Memory-side responder for the cache interface: services the instruction cache (iREN) and the data cache (dREN/dWEN, two-word block fills and write-backs) and drives the single-port RAM. Sits between the caches and RAM in the single-core datapath. Arbitration is registered. The data cache has priority, but a last-grant fairness rule keeps fetch from starving. A data block transfer of up to two words is held atomic.

## Interface
- Parameters: none. Address/data widths come from `cpu_types_pkg` (`word_t`, 32 bits).
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iwait  out  1  high = instruction request not complete.
- iload  out  32  instruction read data; valid when iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  32  data word address.
- dstore  in  32  data write value.
- dwait  out  1  high = data request not complete.
- dload  out  32  data read data; valid when dwait is low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  `ramstate_t`  one of FREE, BUSY, ACCESS, ERROR.
- ram_err  out  1  sticky; set on any ERROR response.

## Operation
- FSM states and transitions:
  - IDLE:
    - dREN|dWEN and (last_grant==I or !iREN) -> DGRANT.
    - Else if iREN -> IGRANT.
  - DGRANT:
    - Drive the RAM from daddr/dstore. ramWEN=dWEN; ramREN=dREN&!dWEN.
    - On completion, increment burst count `bcnt` (1 bit).
    - If bcnt==0 and dREN|dWEN is still high next cycle, stay; otherwise go to IDLE.
    - Set last_grant=D.
  - IGRANT:
    - Drive ramREN=1 and ramaddr=iaddr.
    - On completion -> IDLE; set last_grant=I.
- Completion = ramstate==ACCESS while in a grant state.
  - Only the granted side's wait goes low, for exactly that cycle.
  - dload/iload = ramload, combinational, in the completion cycle.
- ERROR is treated as a completion: wait goes low, load data = ramload, ram_err is set and stays set until reset.
- The requester dropping its enable before completion aborts the grant: return to IDLE next cycle, wait stays high, bcnt is cleared.
- Wait outputs:
  - iwait=1 whenever state≠IGRANT or there is no completion.
  - dwait likewise for DGRANT.
- RAM enables are 0 in IDLE; ramaddr/ramstore are 0 in IDLE.
- Reset values: state=IDLE, last_grant=I, bcnt=0, ram_err=0, iwait=dwait=1, RAM enables 0, loads 0.
- Reset asserted mid-transaction: everything returns to reset values immediately. No completion is reported.

## Timing
- Arbitration latency: 1 cycle (IDLE -> grant).
- Minimum request-to-completion time: 2 cycles (grant entry, then ACCESS in the same grant cycle).
- Back-to-back data words inside a burst: no IDLE bubble. Word 2 is driven in the cycle after word 1 completes.
- Between bursts: at least 1 IDLE cycle, which lets a pending iREN win.
- Address, data and enables must stay stable while the granted wait is high. The arbiter registers nothing from the request path.

## Configuration
- `MEM_ARBITER_STATS_EN`
  - When defined, adds outputs `icount`, `dcount` and `stallcount` (32 bits each, reset 0, wrapping).
    - icount and dcount increment on each completed I/D access.
    - stallcount increments every cycle in which a grant state sees BUSY.
  - When undefined, these ports and counters do not exist. Functional behaviour is identical.

## Structure
- `cpu_types_pkg` holds `ramstate_t`, `word_t`, and the new `arbstate_t` enum {IDLE, DGRANT, IGRANT}.
- One sub-module is natural: `arb_stats` contains the three counters. It is instantiated only under `MEM_ARBITER_STATS_EN`.

## Test plan
- Reset, then iREN=1, iaddr=0x40; RAM returns BUSY, BUSY, ACCESS with ramload=0xDEADBEEF.
  - Expect ramREN=1, ramaddr=0x40, iwait low for one cycle, iload=0xDEADBEEF.
- dREN and iREN both high from IDLE with last_grant=I.
  - Expect the D grant first: word at 0x100, then word at 0x104 with no IDLE gap.
  - Then 1 IDLE cycle, then an I grant.
- dWEN=1 with dREN=1, daddr=0x3100, dstore=0x7.
  - Expect ramWEN=1, ramREN=0, ramstore=0x7; dwait low on ACCESS.
- Continuous dWEN stream (8-word flush) with iREN held high.
  - Expect an I completion interleaved after every 2 D completions; iwait is never high for more than 4 grant turns.
- ramstate=ERROR during an I grant.
  - Expect iwait low for one cycle and ram_err=1, held through later successful accesses until nRST.
- nRST asserted mid DGRANT while ramstate=BUSY.
  - Expect immediate IDLE, dwait=1, ramREN/ramWEN=0, bcnt=0; no spurious completion after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, word type and arbiter FSM encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} arbstate_t;

   typedef enum logic {GNT_I, GNT_D} grant_t;

   // An ERROR response ends the access just like ACCESS does.
   function automatic logic ram_done(input ramstate_t s);
      return (s == ACCESS) || (s == ERROR);
   endfunction

endpackage

// File: rtl/arb_stats.sv
// Access and stall counters for mem_arbiter; only instantiated when MEM_ARBITER_STATS_EN is defined.
module arb_stats
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  i_done_i,
   input  logic  d_done_i,
   input  logic  stall_i,
   output word_t icount_o,
   output word_t dcount_o,
   output word_t stallcount_o
);

   word_t icount_q, dcount_q, stall_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         icount_q <= '0;
         dcount_q <= '0;
         stall_q  <= '0;
      end else begin
         if (i_done_i) icount_q <= icount_q + 32'd1;
         if (d_done_i) dcount_q <= dcount_q + 32'd1;
         if (stall_i)  stall_q  <= stall_q + 32'd1;
      end
   end

   assign icount_o     = icount_q;
   assign dcount_o     = dcount_q;
   assign stallcount_o = stall_q;

endmodule

// File: rtl/mem_arbiter.sv
// Cache-to-RAM arbiter: data cache has priority, last-grant fairness for fetch, two-word data bursts.
// Optional counters (icount/dcount/stallcount) are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter
   import cpu_types_pkg::*;
(
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      ram_err
`ifdef MEM_ARBITER_STATS_EN
   ,
   output word_t     icount,
   output word_t     dcount,
   output word_t     stallcount
`endif
);

   arbstate_t state_q, state_d;
   grant_t    last_q, last_d;
   logic      bcnt_q, bcnt_d;
   logic      err_q, err_d;

   logic d_req, i_done, d_done;

   assign d_req = dREN | dWEN;

   // A side only completes while it is granted and still requesting.
   assign i_done = (state_q == IGRANT) && iREN  && ram_done(ramstate);
   assign d_done = (state_q == DGRANT) && d_req && ram_done(ramstate);

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      last_d  = last_q;
      bcnt_d  = bcnt_q;
      err_d   = err_q | ((i_done | d_done) && (ramstate == ERROR));
      case (state_q)
         IDLE: begin
            if (d_req && (last_q == GNT_I || !iREN)) begin
               state_d = DGRANT;
               last_d  = GNT_D;
            end else if (iREN) begin
               state_d = IGRANT;
            end
         end
         DGRANT: begin
            if (!d_req) begin
               state_d = IDLE;
               bcnt_d  = 1'b0;
            end else if (d_done) begin
               bcnt_d = ~bcnt_q;
               if (bcnt_q) state_d = IDLE;
            end
         end
         IGRANT: begin
            if (i_done) last_d = GNT_I;
            if (!iREN || i_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!nRST) begin
         state_q <= IDLE;
         last_q  <= GNT_I;
         bcnt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         bcnt_q  <= bcnt_d;
         err_q   <= err_d;
      end
   end

   // RAM side follows the request path combinationally; nothing is registered from it.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state_q)
         DGRANT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end
         IGRANT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
         end
         default: ;
      endcase
   end

   assign iwait   = ~i_done;
   assign dwait   = ~d_done;
   assign iload   = i_done ? ramload : '0;
   assign dload   = d_done ? ramload : '0;
   assign ram_err = err_q;

`ifdef MEM_ARBITER_STATS_EN
   logic stall;
   assign stall = (state_q != IDLE) && (ramstate == BUSY);

   arb_stats u_stats (
      .CLK          (CLK),
      .nRST         (nRST),
      .i_done_i     (i_done),
      .d_done_i     (d_done),
      .stall_i      (stall),
      .icount_o     (icount),
      .dcount_o     (dcount),
      .stallcount_o (stallcount)
   );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, D bursts, writes, fairness under flush, ERROR, mid-burst reset.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic      CLK;
   logic      nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   ramstate_t ramstate;
   logic      iwait, dwait, ramREN, ramWEN, ram_err;
   word_t     iload, dload, ramaddr, ramstore;
`ifdef MEM_ARBITER_STATS_EN
   word_t     icount, dcount, stallcount;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   mem_arbiter dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .ram_err  (ram_err)
`ifdef MEM_ARBITER_STATS_EN
      ,
      .icount     (icount),
      .dcount     (dcount),
      .stallcount (stallcount)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin : stim
      byte   evq[$];
      string exp_seq;
      int    dn;
      logic [7:0] exp_c;

      nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
      #2;
      check("rst_iwait",   32'(iwait),   32'd1);
      check("rst_dwait",   32'(dwait),   32'd1);
      check("rst_ramREN",  32'(ramREN),  32'd0);
      check("rst_ramWEN",  32'(ramWEN),  32'd0);
      check("rst_ramaddr", ramaddr,      32'h0);
      check("rst_loads",   iload | dload, 32'h0);
      check("rst_err",     32'(ram_err), 32'd0);
      step();
      nRST = 1'b1;

      // Instruction fetch: BUSY, BUSY, ACCESS.
      step(); iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; settle();
      check("i_idle_ramREN", 32'(ramREN), 32'd0);
      step(); settle();
      check("i_g_ramREN",  32'(ramREN), 32'd1);
      check("i_g_ramaddr", ramaddr,     32'h40);
      check("i_busy_wait", 32'(iwait),  32'd1);
      step(); settle();
      check("i_busy2_wait", 32'(iwait), 32'd1);
      step(); ramstate = ACCESS; ramload = 32'hDEADBEEF; settle();
      check("i_acc_wait", 32'(iwait), 32'd0);
      check("i_acc_load", iload,      32'hDEADBEEF);
      check("i_acc_dwait", 32'(dwait), 32'd1);
      step(); iREN = 1'b0; ramstate = FREE; settle();
      check("i_after_wait",   32'(iwait),  32'd1);
      check("i_after_ramREN", 32'(ramREN), 32'd0);

      // D and I together with last_grant=I: two-word D burst, idle, then I.
      step(); dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h200; settle();
      check("b_idle_dwait", 32'(dwait), 32'd1);
      step(); ramstate = ACCESS; ramload = 32'h11; settle();
      check("b_w1_addr",  ramaddr,     32'h100);
      check("b_w1_ren",   32'(ramREN), 32'd1);
      check("b_w1_dwait", 32'(dwait),  32'd0);
      check("b_w1_dload", dload,       32'h11);
      check("b_w1_iwait", 32'(iwait),  32'd1);
      step(); daddr = 32'h104; ramload = 32'h22; settle();
      check("b_w2_addr",  ramaddr,    32'h104);
      check("b_w2_dwait", 32'(dwait), 32'd0);
      check("b_w2_dload", dload,      32'h22);
      step(); daddr = 32'h108; ramstate = FREE; settle();
      check("b_gap_ren",  32'(ramREN), 32'd0);
      check("b_gap_addr", ramaddr,     32'h0);
      check("b_gap_dwait", 32'(dwait), 32'd1);
      step(); ramstate = ACCESS; ramload = 32'h33; settle();
      check("b_i_addr",  ramaddr,    32'h200);
      check("b_i_iwait", 32'(iwait), 32'd0);
      check("b_i_iload", iload,      32'h33);
      check("b_i_dwait", 32'(dwait), 32'd1);
      step(); dREN = 1'b0; iREN = 1'b0; ramstate = FREE; settle();

      // Single write with dREN also high: write wins.
      step(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h7; settle();
      step(); ramstate = BUSY; settle();
      check("w_ramWEN",   32'(ramWEN), 32'd1);
      check("w_ramREN",   32'(ramREN), 32'd0);
      check("w_ramstore", ramstore,    32'h7);
      check("w_ramaddr",  ramaddr,     32'h3100);
      check("w_busy_dwait", 32'(dwait), 32'd1);
      step(); ramstate = ACCESS; settle();
      check("w_acc_dwait", 32'(dwait), 32'd0);
      step(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; settle();
      check("w_drop_dwait",  32'(dwait),  32'd1);
      check("w_drop_ramWEN", 32'(ramWEN), 32'd0);

      // 8-word flush with fetch pending: last_grant=D here, so I goes first.
      exp_seq = "IDDIDDIDDIDD";
      dn = 0;
      step(); iREN = 1'b1; dWEN = 1'b1; iaddr = 32'h500; ramstate = ACCESS;
      for (int c = 0; c < 60 && dn < 8; c++) begin
         daddr  = 32'h1000 + 32'(4 * dn);
         dstore = 32'(dn);
         settle();
         if (!iwait) evq.push_back(8'h49);
         if (!dwait) begin
            evq.push_back(8'h44);
            check("f_ramstore", ramstore, 32'(dn));
            dn++;
         end
         step();
      end
      iREN = 1'b0; dWEN = 1'b0; ramstate = FREE; settle();
      check("f_events", 32'(evq.size()), 32'd12);
      for (int k = 0; k < 12; k++) begin
         exp_c = exp_seq[k];
         check($sformatf("f_ev%0d", k), (k < evq.size()) ? 32'(evq[k]) : 32'hFFFF_FFFF, 32'(exp_c));
      end

      // ERROR during an I grant: completes, ram_err sticks.
      step(); iREN = 1'b1; iaddr = 32'h80; settle();
      step(); ramstate = ERROR; ramload = 32'hBAD; settle();
      check("e_iwait", 32'(iwait), 32'd0);
      check("e_iload", iload,      32'hBAD);
      step(); iREN = 1'b0; ramstate = FREE; settle();
      check("e_err_set", 32'(ram_err), 32'd1);
      check("e_iwait_after", 32'(iwait), 32'd1);
      step(); dREN = 1'b1; daddr = 32'h200; settle();
      step(); ramstate = ACCESS; ramload = 32'h55; settle();
      check("e_d_dwait", 32'(dwait),  32'd0);
      check("e_d_dload", dload,       32'h55);
      check("e_err_held", 32'(ram_err), 32'd1);
      step(); dREN = 1'b0; ramstate = FREE; settle();
      check("e_abort_dwait", 32'(dwait), 32'd1);
      step(); settle();
      check("e_err_held2", 32'(ram_err), 32'd1);

      // Reset in the middle of a D grant while RAM is BUSY.
      step(); dREN = 1'b1; daddr = 32'h300; settle();
      step(); ramstate = BUSY; settle();
      check("r_pre_ramREN", 32'(ramREN), 32'd1);
      nRST = 1'b0;
      #1;
      check("r_ramREN",  32'(ramREN),  32'd0);
      check("r_ramWEN",  32'(ramWEN),  32'd0);
      check("r_dwait",   32'(dwait),   32'd1);
      check("r_ramaddr", ramaddr,      32'h0);
      check("r_err_clr", 32'(ram_err), 32'd0);
      step(); nRST = 1'b1; ramstate = ACCESS; ramload = 32'h66; settle();
      check("r_idle_dwait",  32'(dwait),  32'd1);
      check("r_idle_ramREN", 32'(ramREN), 32'd0);
      step(); settle();
      check("r_w1_dwait", 32'(dwait), 32'd0);
      check("r_w1_dload", dload,      32'h66);
      step(); settle();
      check("r_w2_dwait", 32'(dwait), 32'd0);
      step(); settle();
      check("r_end_dwait",  32'(dwait),  32'd1);
      check("r_end_ramREN", 32'(ramREN), 32'd0);
      step(); dREN = 1'b0; ramstate = FREE;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
